song_sequencer: RTL and testbench

Tempo-driven sequencer that steps a synchronous note ROM and presents one note code at a time to the tone-selection mux, which maps codes to the 16-bit note period. It replaces a free-running note counter with play, stop, pause and loop control, run-time tempo, and a release gap on `gate` so repeated notes re-articulate. It sits between the front-panel control logic and the note-code → period mux.

---
 rtl/song_sequencer.sv | 167 ++++++++++++++++
 tb/tb_song_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_sequencer.sv
// song_sequencer: tempo-driven note ROM stepper with play/stop/pause/loop.
// Ports:
//   clk50, reset        - clock, synchronous active-high reset
//   play, stop          - start / abort pulses (stop wins)
//   pause, loop_en      - hold playback / wrap after last note
//   song_len, tempo_div - song length and cycles per note, latched on play
//   rom_addr, rom_data  - synchronous note ROM port (1-cycle latency)
//   note_code, gate     - current note and sounding flag
//   busy, step, done    - activity level, end-of-note and end-of-song pulses
module song_sequencer #(
   parameter int ADDR_W     = 7,
   parameter int GAP_CYCLES = 250000
) (
   input  logic              clk50,
   input  logic              reset,
   input  logic              play,
   input  logic              stop,
   input  logic              pause,
   input  logic              loop_en,
   input  logic [ADDR_W-1:0] song_len,
   input  logic [23:0]       tempo_div,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [5:0]        rom_data,
   output logic [5:0]        note_code,
   output logic              gate,
   output logic              busy,
   output logic              step,
   output logic              done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_PLAY
   } state_t;

   localparam logic [23:0] GAP = 24'(GAP_CYCLES);
   // Shortest tempo that still leaves gate high for some cycles.
   localparam logic [23:0] MIN_TEMPO = 24'(GAP_CYCLES + 2);
   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] len_q, len_d;
   logic [23:0]       tempo_q, tempo_d;
   logic [23:0]       tick_q, tick_d;
   logic [5:0]        note_q, note_d;
   logic [ADDR_W-1:0] raddr_q, raddr_d;
   logic              gate_q, gate_d;
   logic              busy_q, busy_d;
   logic              step_q, step_d;
   logic              done_q, done_d;

   always_ff @(posedge clk50) begin
      if (reset) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         tempo_q <= '0;
         tick_q  <= '0;
         note_q  <= '0;
         raddr_q <= '0;
         gate_q  <= 1'b0;
         busy_q  <= 1'b0;
         step_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         tempo_q <= tempo_d;
         tick_q  <= tick_d;
         note_q  <= note_d;
         raddr_q <= raddr_d;
         gate_q  <= gate_d;
         busy_q  <= busy_d;
         step_q  <= step_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      len_d   = len_q;
      tempo_d = tempo_q;
      tick_d  = tick_q;
      note_d  = note_q;
      raddr_d = raddr_q;
      gate_d  = 1'b0;
      step_d  = 1'b0;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (play && !stop && song_len != '0) begin
               len_d   = song_len;
               tempo_d = (tempo_div < MIN_TEMPO) ?
                         MIN_TEMPO : tempo_div;
               addr_d  = '0;
               raddr_d = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            state_d = S_LOAD;
         end
         S_LOAD: begin
            // Tick 0 is always below tempo-GAP thanks to the clamp.
            note_d  = rom_data;
            tick_d  = '0;
            gate_d  = (rom_data != '0) && !pause;
            state_d = S_PLAY;
         end
         S_PLAY: begin
            if (pause) begin
               gate_d = 1'b0;
            end else if (tick_q == tempo_q - 24'd1) begin
               step_d = 1'b1;
               if (addr_q != len_q - ONE) begin
                  addr_d  = addr_q + ONE;
                  raddr_d = addr_q + ONE;
                  state_d = S_FETCH;
               end else if (loop_en) begin
                  addr_d  = '0;
                  raddr_d = '0;
                  state_d = S_FETCH;
               end else begin
                  done_d  = 1'b1;
                  note_d  = '0;
                  raddr_d = '0;
                  state_d = S_IDLE;
               end
            end else begin
               tick_d = tick_q + 24'd1;
               gate_d = (note_q != '0) &&
                        (tick_d < tempo_q - GAP);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (stop && state_q != S_IDLE) begin
         state_d = S_IDLE;
         addr_d  = '0;
         tick_d  = '0;
         note_d  = '0;
         raddr_d = '0;
         gate_d  = 1'b0;
         step_d  = 1'b0;
         done_d  = 1'b0;
      end

      busy_d = (state_d != S_IDLE);
   end

   assign rom_addr  = raddr_q;
   assign note_code = note_q;
   assign gate      = gate_q;
   assign busy      = busy_q;
   assign step      = step_q;
   assign done      = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: directed bench for song_sequencer.
// GAP_CYCLES=2, tempo 10, ROM = 5, 0, 5, 13.
module tb_song_sequencer;

   localparam int AW = 7;

   logic          clk50 = 1'b0;
   logic          reset = 1'b1;
   logic          play = 1'b0;
   logic          stop = 1'b0;
   logic          pause = 1'b0;
   logic          loop_en = 1'b0;
   logic [AW-1:0] song_len = '0;
   logic [23:0]   tempo_div = 24'd10;
   logic [AW-1:0] rom_addr;
   logic [5:0]    rom_data = '0;
   logic [5:0]    note_code;
   logic          gate;
   logic          busy;
   logic          step;
   logic          done;

   int n_chk = 0;
   int n_fail = 0;

   logic [5:0]    rom [128];
   logic [5:0]    r_note [64];
   logic [AW-1:0] r_addr [64];
   logic          r_gate [64];
   logic          r_step [64];
   logic          r_done [64];
   logic          r_busy [64];

   song_sequencer #(
      .ADDR_W    (AW),
      .GAP_CYCLES(2)
   ) dut (
      .clk50    (clk50),
      .reset    (reset),
      .play     (play),
      .stop     (stop),
      .pause    (pause),
      .loop_en  (loop_en),
      .song_len (song_len),
      .tempo_div(tempo_div),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .note_code(note_code),
      .gate     (gate),
      .busy     (busy),
      .step     (step),
      .done     (done)
   );

   always #5 clk50 = ~clk50;

   always @(posedge clk50) rom_data <= rom[rom_addr];

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d",
                  tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk50);
   endtask

   // Sample n cycles; pause high for pl cycles from index ps,
   // play pulsed at index pp (-1 for none).
   task automatic rec(input int n, input int ps,
                      input int pl, input int pp);
      for (int i = 0; i < n; i++) begin
         r_note[i] = note_code;
         r_addr[i] = rom_addr;
         r_gate[i] = gate;
         r_step[i] = step;
         r_done[i] = done;
         r_busy[i] = busy;
         pause = (i >= ps) && (i < ps + pl);
         play  = (i == pp);
         @(negedge clk50);
      end
      pause = 1'b0;
      play  = 1'b0;
   endtask

   function automatic int n_gate(input int a, input int b);
      int s = 0;
      for (int i = a; i <= b; i++) s += int'(r_gate[i]);
      return s;
   endfunction

   function automatic int n_step(input int a, input int b);
      int s = 0;
      for (int i = a; i <= b; i++) s += int'(r_step[i]);
      return s;
   endfunction

   function automatic int n_done(input int a, input int b);
      int s = 0;
      for (int i = a; i <= b; i++) s += int'(r_done[i]);
      return s;
   endfunction

   function automatic int n_note(input int a, input int b,
                                 input logic [5:0] c);
      int s = 0;
      for (int i = a; i <= b; i++) s += int'(r_note[i] == c);
      return s;
   endfunction

   // Pulse play; returns on the first PLAY cycle.
   task automatic start_song();
      play = 1'b1;
      cyc(1);
      play = 1'b0;
      cyc(2);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_gate"}, 32'(gate), 0);
      check({tag, "_note"}, 32'(note_code), 0);
      check({tag, "_addr"}, 32'(rom_addr), 0);
      check({tag, "_step"}, 32'(step), 0);
      check({tag, "_done"}, 32'(done), 0);
   endtask

   logic [5:0] exp_code [4];
   int         exp_gate [4];
   int         act;

   initial begin
      for (int i = 0; i < 128; i++) rom[i] = '0;
      rom[0] = 6'd5;
      rom[1] = 6'd0;
      rom[2] = 6'd5;
      rom[3] = 6'd13;
      exp_code[0] = 6'd5;  exp_gate[0] = 8;
      exp_code[1] = 6'd0;  exp_gate[1] = 0;
      exp_code[2] = 6'd5;  exp_gate[2] = 8;
      exp_code[3] = 6'd13; exp_gate[3] = 8;

      cyc(3);
      check_idle("rst");
      reset = 1'b0;
      cyc(1);

      // Basic play, with a stray play at index 20.
      song_len = 7'd4;
      play = 1'b1;
      cyc(1);
      play = 1'b0;
      check("bas_busy0", 32'(busy), 1);
      check("bas_addr0", 32'(rom_addr), 0);
      check("bas_gate0", 32'(gate), 0);
      cyc(2);
      rec(48, 99, 0, 20);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("bas_note%0d", k),
               32'(n_note(12*k, 12*k+9, exp_code[k])), 10);
         check($sformatf("bas_gate%0d", k),
               32'(n_gate(12*k, 12*k+11)), 32'(exp_gate[k]));
         check($sformatf("bas_step%0d", k),
               32'(r_step[12*k+10]), 1);
      end
      for (int k = 0; k < 3; k++)
         check($sformatf("bas_fetch%0d", k),
               32'(r_addr[12*k+10]), 32'(k+1));
      check("bas_nstep", 32'(n_step(0, 47)), 4);
      check("bas_ndone", 32'(n_done(0, 47)), 1);
      check("bas_done", 32'(r_done[46]), 1);
      check("bas_busy45", 32'(r_busy[45]), 1);
      check("bas_busy46", 32'(r_busy[46]), 0);
      check("bas_note46", 32'(r_note[46]), 0);

      // Loop, then stop.
      loop_en = 1'b1;
      start_song();
      rec(61, 99, 0, -1);
      check("lp_addr", 32'(r_addr[46]), 0);
      check("lp_step", 32'(r_step[46]), 1);
      check("lp_busy", 32'(r_busy[46]), 1);
      check("lp_note", 32'(r_note[48]), 5);
      check("lp_ndone", 32'(n_done(0, 60)), 0);
      check("lp_addr1", 32'(r_addr[58]), 1);
      stop = 1'b1;
      cyc(1);
      stop = 1'b0;
      check_idle("lp_stop");
      loop_en = 1'b0;

      // Pause for 7 cycles at tick 3 of the first note.
      start_song();
      rec(20, 3, 7, -1);
      check("pz_gate3", 32'(r_gate[3]), 1);
      check("pz_gatelo", 32'(n_gate(4, 10)), 0);
      check("pz_gate11", 32'(r_gate[11]), 1);
      check("pz_ngate", 32'(n_gate(0, 17)), 8);
      check("pz_note", 32'(n_note(0, 16, 6'd5)), 17);
      check("pz_step10", 32'(r_step[10]), 0);
      check("pz_step17", 32'(r_step[17]), 1);
      check("pz_nstep", 32'(n_step(0, 17)), 1);
      stop = 1'b1;
      cyc(1);
      stop = 1'b0;
      check("pz_stop", 32'(busy), 0);

      // Tempo clamp: tempo 1 becomes 4.
      tempo_div = 24'd1;
      song_len = 7'd2;
      start_song();
      rec(12, 99, 0, -1);
      check("cl_ngate", 32'(n_gate(0, 5)), 2);
      check("cl_gate1", 32'(r_gate[1]), 1);
      check("cl_step", 32'(r_step[4]), 1);
      check("cl_nstep", 32'(n_step(0, 3)), 0);
      check("cl_note", 32'(n_note(6, 9, 6'd0)), 4);
      check("cl_done", 32'(r_done[10]), 1);
      check("cl_busy", 32'(r_busy[10]), 0);
      tempo_div = 24'd10;

      // Zero length play is ignored.
      song_len = 7'd0;
      play = 1'b1;
      cyc(1);
      play = 1'b0;
      act = 0;
      for (int i = 0; i < 5; i++) begin
         act += int'(busy) + int'(rom_addr != '0);
         cyc(1);
      end
      check("zl_act", 32'(act), 0);

      // Play and stop together from IDLE.
      song_len = 7'd4;
      play = 1'b1;
      stop = 1'b1;
      cyc(1);
      play = 1'b0;
      stop = 1'b0;
      check("ps_busy", 32'(busy), 0);
      cyc(3);
      check("ps_busy3", 32'(busy), 0);

      // Reset during PLAY of the third note.
      start_song();
      rec(27, 99, 0, -1);
      check("rs_pre_note", 32'(note_code), 5);
      check("rs_pre_addr", 32'(rom_addr), 2);
      check("rs_pre_gate", 32'(gate), 1);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      check_idle("rs");
      start_song();
      check("rs_note", 32'(note_code), 5);
      check("rs_gate", 32'(gate), 1);
      cyc(10);
      check("rs_step", 32'(step), 1);
      check("rs_addr", 32'(rom_addr), 1);
      stop = 1'b1;
      cyc(1);
      stop = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
